// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: register-bus transfer sequencer (SYSCLK, RESET, req_* in; req_ready, oe, hold, latch, busy, done, err out)
module bus_xfer_seq #(
  parameter int NSRC = 6,
  parameter int NDST = 8,
  parameter int SETTLE = 1,
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int CW = $clog2(SETTLE + 1)
) (
  input  logic            SYSCLK,
  input  logic            RESET,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SW-1:0]   req_src,
  input  logic [NDST-1:0] req_dst,
  output logic [NSRC-1:0] oe,
  output logic            hold,
  output logic [NDST-1:0] latch,
  output logic            busy,
  output logic            done,
  output logic            err
);
  typedef enum logic [2:0] {IDLE, DRIVE, HOLD, STROBE, RELEASE} state_t;
  state_t state, state_n;
  logic [SW-1:0] q_src [2];
  logic [NDST-1:0] q_dst [2];
  logic wp, rp;
  logic [1:0] cnt;
  logic [CW-1:0] sc, sc_n;
  logic [SW-1:0] cur_src, src_n;
  logic [NDST-1:0] cur_dst, dst_n;
  logic empty, push, pop, head_ok, go, drv;
  assign empty = cnt == 2'd0;
  assign req_ready = cnt != 2'd2;
  assign push = req_valid & req_ready;
  assign head_ok = (int'(q_src[rp]) < NSRC) & (|q_dst[rp]);
  assign pop = (state == IDLE || state == RELEASE) && !empty;
  assign go = pop & head_ok;
  assign busy = (state != IDLE) | !empty;
  assign src_n = go ? q_src[rp] : cur_src;
  assign dst_n = go ? q_dst[rp] : cur_dst;
  assign drv = state_n == DRIVE || state_n == HOLD || state_n == STROBE;
  always_comb begin
    state_n = state;
    sc_n = sc;
    case (state)
      IDLE: begin
        state_n = go ? DRIVE : IDLE;
        sc_n = '0;
      end
      DRIVE: begin
        state_n = (sc == CW'(SETTLE - 1)) ? HOLD : DRIVE;
        sc_n = sc + 1'b1;
      end
      HOLD: state_n = STROBE;
      STROBE: state_n = RELEASE;
      RELEASE: begin
        state_n = go ? DRIVE : IDLE;
        sc_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they change on the same edge as the FSM
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      sc <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      cur_src <= '0;
      cur_dst <= '0;
      oe <= '0;
      hold <= 1'b0;
      latch <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      sc <= sc_n;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
      cur_src <= src_n;
      cur_dst <= dst_n;
      oe <= drv ? NSRC'(1) << src_n : '0;
      hold <= state_n == HOLD || state_n == STROBE || state_n == RELEASE;
      latch <= (state_n == STROBE) ? dst_n : '0;
      done <= state_n == RELEASE;
      err <= pop & !head_ok;
    end
  end
  always_ff @(posedge SYSCLK) begin
    if (push) begin
      q_src[wp] <= req_src;
      q_dst[wp] <= req_dst;
    end
  end
endmodule

// File: tb/tb_bus_xfer_seq.sv
// tb_bus_xfer_seq: directed self-checking bench for bus_xfer_seq (SETTLE=1 and SETTLE=3 instances)
module tb_bus_xfer_seq;
  logic SYSCLK = 1'b0, RESET = 1'b1;
  logic req_valid = 1'b0, req_ready, hold, busy, done, err;
  logic [2:0] req_src = '0;
  logic [7:0] req_dst = '0, latch;
  logic [5:0] oe;
  logic v2 = 1'b0, r2, h2, b2, dn2, e2;
  logic [2:0] s2 = '0;
  logic [7:0] d2 = '0, l2;
  logic [5:0] o2;
  int checks = 0, errors = 0;
  always #5 SYSCLK = ~SYSCLK;
  bus_xfer_seq #(.NSRC(6), .NDST(8), .SETTLE(1)) u1 (
    .SYSCLK(SYSCLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .oe(oe), .hold(hold), .latch(latch),
    .busy(busy), .done(done), .err(err));
  bus_xfer_seq #(.NSRC(6), .NDST(8), .SETTLE(3)) u2 (
    .SYSCLK(SYSCLK), .RESET(RESET), .req_valid(v2), .req_ready(r2),
    .req_src(s2), .req_dst(d2), .oe(o2), .hold(h2), .latch(l2),
    .busy(b2), .done(dn2), .err(e2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask
  task automatic push(input logic [2:0] s, input logic [7:0] d);
    req_valid = 1'b1;
    req_src = s;
    req_dst = d;
    tick();
    req_valid = 1'b0;
  endtask
  initial begin
    tick();
    check("rst_oe", 32'(oe), 0);
    check("rst_hold", 32'(hold), 0);
    check("rst_latch", 32'(latch), 0);
    check("rst_done_err", 32'({done, err}), 0);
    RESET = 1'b0;
    tick();
    check("rst_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    push(3'd2, 8'h01);
    check("t1_e0_oe", 32'(oe), 0);
    check("t1_e0_busy", 32'(busy), 1);
    tick();
    check("t1_e1_oe", 32'(oe), 32'h04);
    check("t1_e1_hold", 32'(hold), 0);
    tick();
    check("t1_e2_oe", 32'(oe), 32'h04);
    check("t1_e2_hold", 32'(hold), 1);
    check("t1_e2_latch", 32'(latch), 0);
    tick();
    check("t1_e3_oe", 32'(oe), 32'h04);
    check("t1_e3_latch", 32'(latch), 32'h01);
    check("t1_e3_hold", 32'(hold), 1);
    tick();
    check("t1_e4_done", 32'(done), 1);
    check("t1_e4_oe", 32'(oe), 0);
    check("t1_e4_hold", 32'(hold), 1);
    check("t1_e4_latch", 32'(latch), 0);
    tick();
    check("t1_e5_done", 32'(done), 0);
    check("t1_e5_hold", 32'(hold), 0);
    check("t1_e5_busy", 32'(busy), 0);
    req_valid = 1'b1; req_src = 3'd0; req_dst = 8'h02;
    tick();
    req_src = 3'd1; req_dst = 8'h04;
    tick();
    req_src = 3'd3; req_dst = 8'h08;
    tick();
    check("t2_e2_ready", 32'(req_ready), 0);
    check("t2_e2_oe", 32'(oe), 32'h01);
    req_src = 3'd4; req_dst = 8'h10;
    for (int e = 3; e <= 17; e++) begin
      logic [5:0] eo;
      tick();
      if (e == 6) req_valid = 1'b0;
      eo = (e <= 3) ? 6'h01 : (e == 4) ? 6'h00 : (e <= 7) ? 6'h02 : (e == 8) ? 6'h00 :
           (e <= 11) ? 6'h08 : (e == 12) ? 6'h00 : (e <= 15) ? 6'h10 : 6'h00;
      check($sformatf("t2_e%0d_oe", e), 32'(oe), 32'(eo));
      check($sformatf("t2_e%0d_done", e), 32'(done), 32'(e == 4 || e == 8 || e == 12 || e == 16));
      if (e <= 5) check($sformatf("t2_e%0d_ready", e), 32'(req_ready), 32'(e == 5));
    end
    check("t2_idle", 32'(busy), 0);
    push(3'd7, 8'h01);
    tick();
    check("t3_src7_err", 32'(err), 1);
    check("t3_src7_oe", 32'(oe), 0);
    check("t3_src7_busy", 32'(busy), 0);
    tick();
    check("t3_src7_err_off", 32'(err), 0);
    check("t3_src7_latch", 32'(latch), 0);
    push(3'd1, 8'h00);
    tick();
    check("t3_dst0_err", 32'(err), 1);
    check("t3_dst0_oe", 32'(oe), 0);
    push(3'd4, 8'h10);
    tick();
    check("t3_after_oe", 32'(oe), 32'h10);
    check("t3_after_err", 32'(err), 0);
    tick(); tick();
    check("t3_after_latch", 32'(latch), 32'h10);
    tick(); tick();
    push(3'd5, 8'hA0);
    tick(); tick();
    check("t4_pre_latch", 32'(latch), 0);
    tick();
    check("t4_latch", 32'(latch), 32'hA0);
    check("t4_oe", 32'(oe), 32'h20);
    tick();
    check("t4_latch_off", 32'(latch), 0);
    tick();
    push(3'd1, 8'hFF);
    tick(); tick();
    check("t5_hold_on", 32'(hold), 1);
    #2 RESET = 1'b1;
    #1;
    check("t5_rst_oe", 32'(oe), 0);
    check("t5_rst_hold", 32'(hold), 0);
    check("t5_rst_latch", 32'(latch), 0);
    tick();
    check("t5_rst_latch2", 32'(latch), 0);
    RESET = 1'b0;
    tick();
    check("t5_post_latch", 32'(latch), 0);
    check("t5_post_busy", 32'(busy), 0);
    check("t5_post_ready", 32'(req_ready), 1);
    check("t5_post_oe", 32'(oe), 0);
    v2 = 1'b1; s2 = 3'd3; d2 = 8'h40;
    tick();
    v2 = 1'b0;
    tick();
    check("t6_e1_oe", 32'(o2), 32'h08);
    tick(); tick();
    check("t6_e3_hold", 32'(h2), 0);
    tick();
    check("t6_e4_hold", 32'(h2), 1);
    check("t6_e4_oe", 32'(o2), 32'h08);
    tick();
    check("t6_e5_latch", 32'(l2), 32'h40);
    check("t6_e5_done", 32'(dn2), 0);
    tick();
    check("t6_e6_done", 32'(dn2), 1);
    check("t6_e6_oe", 32'(o2), 0);
    tick();
    check("t6_e7_busy", 32'(b2), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
